// File: rtl/sram_like_responder.sv
// SRAM-like bus responder: accepts req/addr_ok transactions into a word RAM and answers in order
// with data_ok after LATENCY cycles. Define SRAM_RESP_STALL_EN to randomly withhold addr_ok.
module sram_like_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  // Handshake: a request is taken at a rising edge when req && addr_ok; every taken request
  // is answered by exactly one data_ok pulse, in acceptance order.

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  logic [31:0]            q_data [OUTSTANDING];
  logic [3:0]             q_cnt  [OUTSTANDING];
  logic [OUTSTANDING-1:0] q_vld;
  logic [OUTSTANDING-1:0] q_wr;
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;

  logic                  gate;
  logic                  accept;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_addr_bits;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUTSTANDING - 1)) return '0;
    else return p + 1'b1;
  endfunction

`ifdef SRAM_RESP_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR for x^16+x^14+x^13+x^11.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign gate = (lfsr[1:0] != 2'b00);
`else
  assign gate = 1'b1;
`endif

  assign idx              = addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  // Slot freed by a same-cycle pop is not reusable until the next cycle.
  assign addr_ok = !reset && (count < CNT_W'(OUTSTANDING)) && gate;
  assign accept  = req && addr_ok;
  assign data_ok = q_vld[head] && (q_cnt[head] == 4'd0);
  assign pop     = data_ok;
  assign rdata   = (data_ok && !q_wr[head]) ? q_data[head] : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_vld <= '0;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (q_vld[i] && (q_cnt[i] != 4'd0)) q_cnt[i] <= q_cnt[i] - 4'd1;
      end
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= next_ptr(head);
      end
      if (accept) begin
        q_vld[tail] <= 1'b1;
        q_wr[tail]  <= wr;
        q_cnt[tail] <= CNT_INIT;
        tail        <= next_ptr(tail);
      end
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end

  // RAM and captured read data are never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      q_data[tail] <= mem[idx];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (accept) begin
      assert (!((size == 2'd2 && addr[1:0] != 2'b00) || (size == 2'd1 && addr[0])))
        else $error("sram_like_responder: misaligned access size=%0d addr=%h", size, addr);
    end
  end
`endif

endmodule
